// File: rtl/input_prep_stage.sv
// Operand preparation stage: fixed-point conversion, halving and squaring of two floats.
// Optional build macro STAGE1_SATURATE_EN clamps out-of-range fixed-point results (default: wrap).
module input_prep_stage #(
  parameter int FLT_DATA_WIDTH    = 32,
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int FRAC_BITS         = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [FLT_DATA_WIDTH-1:0]    x_one,
  input  logic [FLT_DATA_WIDTH-1:0]    x_two,
  output logic                         done,
  output logic                         working,
  output logic [CORDIC_DATA_WIDTH-1:0] out_one,
  output logic [CORDIC_DATA_WIDTH-1:0] out_two,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_two,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_two
);

  localparam int CW = CORDIC_DATA_WIDTH;
  // Exponent thresholds for x*2^FRAC_BITS: below MIN_EXP truncates to 0, from OVF_EXP up is out of range.
  localparam logic [7:0] SHIFT_BASE = 8'(127 + 23 - FRAC_BITS);
  localparam logic [7:0] MIN_EXP    = 8'(127 - FRAC_BITS);
  localparam logic [7:0] OVF_EXP    = 8'(127 + CW - 1 - FRAC_BITS);
  localparam logic [CW-1:0] POS_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] NEG_MIN = {1'b1, {(CW-1){1'b0}}};

  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_INF  = 2'd2;
  localparam logic [1:0] K_NAN  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_COMPUTE, S_RESULT} state_t;

  state_t r_state;
  logic   r_done;
  logic   r_working;

  function automatic logic [CW-1:0] to_fixed(input logic [31:0] x);
    logic [7:0]    e;
    logic [23:0]   m;
    logic [CW-1:0] mag;
    logic [CW-1:0] res;
    e   = x[30:23];
    m   = {1'b1, x[22:0]};
    mag = '0;
    res = '0;
    if (e == 8'hFF) begin
      res = (x[22:0] != 23'd0) ? '0 : (x[31] ? NEG_MIN : POS_MAX);
    end else if (e >= MIN_EXP) begin
      if (e >= SHIFT_BASE) begin
        if ((e - SHIFT_BASE) < 8'(CW))
          mag = CW'({{CW{1'b0}}, m} << (e - SHIFT_BASE));
      end else begin
        mag = CW'({{CW{1'b0}}, m} >> (SHIFT_BASE - e));
      end
      res = x[31] ? -mag : mag;
`ifdef STAGE1_SATURATE_EN
      // Exactly -2^21 is still representable, so it is not clamped.
      if ((e >= OVF_EXP) && !(x[31] && (e == OVF_EXP) && (x[22:0] == 23'd0)))
        res = x[31] ? NEG_MIN : POS_MAX;
`endif
    end
    return res;
  endfunction

  function automatic logic [31:0] halve(input logic [31:0] x);
    if (x[30:23] == 8'hFF)
      return x;
    else if (x[30:23] <= 8'd1)
      return {x[31], 31'd0};
    else
      return {x[31], x[30:23] - 8'd1, x[22:0]};
  endfunction

  // p holds product bits [47:23]; ex0 is the biased exponent before normalisation.
  function automatic logic [31:0] sq_finish(input logic [24:0] p,
                                            input logic signed [10:0] ex0,
                                            input logic [1:0] kind);
    logic signed [10:0] ex;
    logic [22:0]        mant;
    ex   = ex0 + (p[24] ? 11'sd1 : 11'sd0);
    mant = p[24] ? p[23:1] : p[22:0];
    case (kind)
      K_ZERO:  return 32'h0000_0000;
      K_INF:   return 32'h7F80_0000;
      K_NAN:   return 32'h7FC0_0000;
      default: begin
        if (ex <= 11'sd0)
          return 32'h0000_0000;
        else if (ex >= 11'sd255)
          return 32'h7F80_0000;
        else
          return {1'b0, 8'(ex), mant};
      end
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_working <= 1'b0;
    end else if (clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CAPTURE;
            r_working <= 1'b1;
          end
        end
        S_CAPTURE: r_state <= S_COMPUTE;
        S_COMPUTE: r_state <= S_RESULT;
        S_RESULT: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b1;
          r_working <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [1:0][31:0]   w_x;
  logic [1:0][CW-1:0] w_fix;
  logic [1:0][31:0]   w_half;
  logic [1:0][31:0]   w_sq;

  assign w_x = {x_two, x_one};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [31:0]        r_x;
      logic [CW-1:0]      r_fix;
      logic [31:0]        r_half;
      logic [24:0]        r_prod;
      logic signed [10:0] r_exp;
      logic [1:0]         r_kind;
      logic [31:0]        r_sq;
      logic [CW-1:0]      r_fix_out;
      logic [31:0]        r_half_out;
      logic [31:0]        r_sq_out;
      logic [23:0]        w_mant;

      assign w_mant = {1'b1, r_x[22:0]};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_x        <= '0;
          r_fix      <= '0;
          r_half     <= '0;
          r_prod     <= '0;
          r_exp      <= '0;
          r_kind     <= K_ZERO;
          r_sq       <= '0;
          r_fix_out  <= '0;
          r_half_out <= '0;
          r_sq_out   <= '0;
        end else if (clk_en) begin
          case (r_state)
            S_IDLE: begin
              if (start) r_x <= w_x[gi];
            end
            S_CAPTURE: begin
              r_fix  <= to_fixed(r_x);
              r_half <= halve(r_x);
              r_prod <= 25'((48'(w_mant) * 48'(w_mant)) >> 23);
              r_exp  <= $signed({2'b00, r_x[30:23], 1'b0}) - 11'sd127;
              if (r_x[30:23] == 8'h00)
                r_kind <= K_ZERO;
              else if (r_x[30:23] == 8'hFF)
                r_kind <= (r_x[22:0] != 23'd0) ? K_NAN : K_INF;
              else
                r_kind <= K_NORM;
            end
            S_COMPUTE: r_sq <= sq_finish(r_prod, r_exp, r_kind);
            S_RESULT: begin
              r_fix_out  <= r_fix;
              r_half_out <= r_half;
              r_sq_out   <= r_sq;
            end
            default: ;
          endcase
        end
      end

      assign w_fix[gi]  = r_fix_out;
      assign w_half[gi] = r_half_out;
      assign w_sq[gi]   = r_sq_out;
    end
  endgenerate

  assign done           = r_done;
  assign working        = r_working;
  assign out_one        = w_fix[0];
  assign out_two        = w_fix[1];
  assign half_out_one   = w_half[0];
  assign half_out_two   = w_half[1];
  assign square_out_one = w_sq[0];
  assign square_out_two = w_sq[1];

endmodule

// File: tb/tb_input_prep_stage.sv
// Directed bench for input_prep_stage: value vectors, latency, clk_en freeze and reset abort.
// Expectations follow STAGE1_SATURATE_EN when it is defined for the build.
module tb_input_prep_stage;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [31:0] x_one;
  logic [31:0] x_two;
  logic        done;
  logic        working;
  logic [21:0] out_one;
  logic [21:0] out_two;
  logic [31:0] half_out_one;
  logic [31:0] half_out_two;
  logic [31:0] square_out_one;
  logic [31:0] square_out_two;

  int checks   = 0;
  int failures = 0;

`ifdef STAGE1_SATURATE_EN
  localparam logic [31:0] E_NEG25 = 32'h200000;
  localparam logic [31:0] E_BIG   = 32'h1FFFFF;
`else
  localparam logic [31:0] E_NEG25 = 32'h180000;
  localparam logic [31:0] E_BIG   = 32'h000000;
`endif

  input_prep_stage dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .start          (start),
    .x_one          (x_one),
    .x_two          (x_two),
    .done           (done),
    .working        (working),
    .out_one        (out_one),
    .out_two        (out_two),
    .half_out_one   (half_out_one),
    .half_out_two   (half_out_two),
    .square_out_one (square_out_one),
    .square_out_two (square_out_two)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag,
                             input logic [31:0] eo1, input logic [31:0] eo2,
                             input logic [31:0] eh1, input logic [31:0] eh2,
                             input logic [31:0] es1, input logic [31:0] es2);
    chk({tag, ".out_one"},        32'(out_one),   eo1);
    chk({tag, ".out_two"},        32'(out_two),   eo2);
    chk({tag, ".half_out_one"},   half_out_one,   eh1);
    chk({tag, ".half_out_two"},   half_out_two,   eh2);
    chk({tag, ".square_out_one"}, square_out_one, es1);
    chk({tag, ".square_out_two"}, square_out_two, es2);
  endtask

  // Called at a falling edge; start is taken at the next rising edge (edge k).
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo1, input logic [31:0] eo2,
                       input logic [31:0] eh1, input logic [31:0] eh2,
                       input logic [31:0] es1, input logic [31:0] es2);
    x_one = a;
    x_two = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".working_k"}, 32'(working), 32'd1);
    chk({tag, ".done_k"},    32'(done),    32'd0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk($sformatf("%s.working_k%0d", tag, i), 32'(working), 32'd1);
      chk($sformatf("%s.done_k%0d", tag, i),    32'(done),    32'd0);
    end
    @(negedge clk);
    chk({tag, ".done_k3"},    32'(done),    32'd1);
    chk({tag, ".working_k3"}, 32'(working), 32'd0);
    chk_outputs(tag, eo1, eo2, eh1, eh2, es1, es2);
    @(negedge clk);
    chk({tag, ".done_k4"}, 32'(done), 32'd0);
    $display("op %s x_one=%h x_two=%h out=%h/%h half=%h/%h square=%h/%h", tag, a, b,
             out_one, out_two, half_out_one, half_out_two, square_out_one, square_out_two);
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    x_one  = '0;
    x_two  = '0;
    repeat (3) @(negedge clk);
    chk("reset.done",    32'(done),    32'd0);
    chk("reset.working", 32'(working), 32'd0);
    chk_outputs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("one_half", 32'h3F800000, 32'h3F000000,
          32'h100000, 32'h080000, 32'h3F000000, 32'h3E800000, 32'h3F800000, 32'h3E800000);
    do_op("neg25_big", 32'hC0200000, 32'h7F000000,
          E_NEG25, E_BIG, 32'hBFA00000, 32'h7E800000, 32'h40C80000, 32'h7F800000);
    do_op("zero_pinf", 32'h00000000, 32'h7F800000,
          32'h000000, 32'h1FFFFF, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h7F800000);
    do_op("nan_ninf", 32'h7FC00001, 32'hFF800000,
          32'h000000, 32'h200000, 32'h7FC00001, 32'hFF800000, 32'h7FC00000, 32'h7F800000);
    do_op("lsb_neg2", 32'h35800000, 32'hC0000000,
          32'h000001, 32'h200000, 32'h35000000, 32'hBF800000, 32'h2B800000, 32'h40800000);
    do_op("max_minnorm", 32'h3FFFFFFF, 32'h80800000,
          32'h1FFFFF, 32'h000000, 32'h3F7FFFFF, 32'h80000000, 32'h407FFFFE, 32'h00000000);
    do_op("subnorm_small", 32'h00000001, 32'h34800000,
          32'h000000, 32'h000000, 32'h00000000, 32'h34000000, 32'h00000000, 32'h29800000);

    // clk_en freeze mid-operation, with a second start while busy.
    x_one = 32'h3FC00000;
    x_two = 32'hBE800000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    clk_en = 1'b0;
    x_one  = 32'h3F800000;
    x_two  = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("freeze.working_%0d", i), 32'(working), 32'd1);
      chk($sformatf("freeze.done_%0d", i),    32'(done),    32'd0);
    end
    clk_en = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    chk("freeze.working_k1", 32'(working), 32'd1);
    chk("freeze.done_k1",    32'(done),    32'd0);
    @(negedge clk);
    chk("freeze.working_k2", 32'(working), 32'd1);
    chk("freeze.done_k2",    32'(done),    32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("freeze.done_k3",    32'(done),    32'd1);
    chk("freeze.working_k3", 32'(working), 32'd0);
    chk_outputs("freeze", 32'h180000, 32'h3C0000, 32'h3F400000, 32'hBE000000,
                32'h40100000, 32'h3D800000);
    $display("op freeze out=%h/%h square=%h/%h", out_one, out_two, square_out_one, square_out_two);
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("stretch.done_%0d", i), 32'(done), 32'd1);
    end
    clk_en = 1'b1;
    @(negedge clk);
    chk("stretch.done_end", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ignored.working_%0d", i), 32'(working), 32'd0);
      chk($sformatf("ignored.done_%0d", i),    32'(done),    32'd0);
    end
    chk("ignored.out_one_held", 32'(out_one), 32'h180000);

    // Reset one edge after acceptance aborts the operation.
    x_one = 32'h40000000;
    x_two = 32'hBF800000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    chk("abort.working", 32'(working), 32'd0);
    chk("abort.done",    32'(done),    32'd0);
    chk_outputs("abort", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort.no_done_%0d", i), 32'(done),    32'd0);
      chk($sformatf("abort.idle_%0d", i),    32'(working), 32'd0);
    end
    $display("op abort working=%0d done=%0d out=%h", working, done, out_one);

    do_op("after_reset", 32'h3F800000, 32'h3F000000,
          32'h100000, 32'h080000, 32'h3F000000, 32'h3E800000, 32'h3F800000, 32'h3E800000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
